map_ram_arbiter: RTL and testbench

- Owns the single read port and the single write port of the 320x240 map RAM (76800 entries, 1-cycle registered read, read-before-write).
- Shares the read port between the VGA scan-out fetch, which has absolute priority and fixed latency, and a game-logic collision/tile query with a req/ack handshake.
- Sequences tile writes from the map update engine.
- Converts (x,y) to a linear address and handles out-of-range coordinates.

---
 rtl/map_pkg.sv | 24 ++
 rtl/map_addr_calc.sv | 25 ++
 rtl/map_ram_arbiter.sv | 162 ++++++++++++++++
 tb/tb_map_ram_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/map_pkg.sv
// Shared constants and state types for the map RAM arbiter.
package map_pkg;

    localparam int MAP_W     = 320;
    localparam int MAP_H     = 240;
    localparam int MAP_DEPTH = MAP_W * MAP_H;
    localparam int ADDR_W    = 19;

    typedef enum logic {OWN_DISP, OWN_QRY} owner_t;

    typedef enum logic [1:0] {
        Q_IDLE,
        Q_WAIT_SLOT,
        Q_INFLIGHT,
        Q_DONE
    } qstate_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_ISSUE,
        W_DONE
    } wstate_t;

endpackage

// File: rtl/map_addr_calc.sv
// Combinational (x,y) to linear map address with out-of-range detection.
module map_addr_calc
    import map_pkg::*;
#(
    parameter int WIDTH  = map_pkg::MAP_W,
    parameter int HEIGHT = map_pkg::MAP_H
) (
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    output logic [ADDR_W-1:0] addr,
    output logic              oob
);

    localparam int LIN_W = $clog2(WIDTH * HEIGHT);

    logic [LIN_W-1:0] lin;

    // Only the in-range result matters, so the product is truncated to the map's index width.
    always_comb begin
        lin  = LIN_W'({9'd0, y} * 19'(WIDTH) + {9'd0, x});
        addr = ADDR_W'(lin);
        oob  = (x >= 10'(WIDTH)) || (y >= 10'(HEIGHT));
    end

endmodule

// File: rtl/map_ram_arbiter.sv
// Map RAM port owner: display fetch has read priority, queries use req/ack, writes are sequenced.
// Define MAP_WRITE_IN_BLANK_EN to allow writes only while disp_blank is high.
module map_ram_arbiter
    import map_pkg::*;
#(
    parameter int              MAP_W     = map_pkg::MAP_W,
    parameter int              MAP_H     = map_pkg::MAP_H,
    parameter int              RD_W      = 5,
    parameter int              WR_W      = 8,
    parameter logic [RD_W-1:0] OOB_VALUE = '0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              disp_req,
    input  logic [9:0]        disp_x,
    input  logic [9:0]        disp_y,
    output logic              disp_valid,
    output logic [RD_W-1:0]   disp_data,
    input  logic              q_req,
    input  logic [9:0]        q_x,
    input  logic [9:0]        q_y,
    output logic              q_ack,
    output logic [RD_W-1:0]   q_data,
    input  logic              w_req,
    input  logic [9:0]        w_x,
    input  logic [9:0]        w_y,
    input  logic [WR_W-1:0]   w_data,
    output logic              w_ack,
    input  logic              disp_blank,
    output logic [ADDR_W-1:0] read_address,
    output logic [ADDR_W-1:0] write_address,
    output logic [WR_W-1:0]   data_In,
    output logic              we,
    input  logic [RD_W-1:0]   data_Out
);

    logic [ADDR_W-1:0] disp_addr, q_addr, w_addr;
    logic              disp_oob, q_oob, w_oob;

    qstate_t           q_state;
    wstate_t           w_state;

    logic              s1_valid, s1_oob;
    owner_t            s1_owner;
    logic              s2_valid, s2_oob;
    owner_t            s2_owner;

    logic              qry_grant;
    logic              write_allowed;
    logic [RD_W-1:0]   rd_value;

    map_addr_calc #(.WIDTH(MAP_W), .HEIGHT(MAP_H)) u_disp_addr (
        .x(disp_x), .y(disp_y), .addr(disp_addr), .oob(disp_oob)
    );
    map_addr_calc #(.WIDTH(MAP_W), .HEIGHT(MAP_H)) u_q_addr (
        .x(q_x), .y(q_y), .addr(q_addr), .oob(q_oob)
    );
    map_addr_calc #(.WIDTH(MAP_W), .HEIGHT(MAP_H)) u_w_addr (
        .x(w_x), .y(w_y), .addr(w_addr), .oob(w_oob)
    );

`ifdef MAP_WRITE_IN_BLANK_EN
    assign write_allowed = disp_blank;
`else
    logic unused_disp_blank;
    assign unused_disp_blank = disp_blank;
    assign write_allowed     = 1'b1;
`endif

    assign qry_grant = (q_state == Q_WAIT_SLOT) && q_req && !disp_req;
    assign rd_value  = s2_oob ? OOB_VALUE : data_Out;

    // Stage 1 drives the RAM address, the middle stage waits out the RAM's registered read,
    // and the output stage captures data_Out, so both owners see exactly two cycles of latency.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            read_address <= '0;
            s1_valid     <= 1'b0;
            s1_oob       <= 1'b0;
            s1_owner     <= OWN_DISP;
            s2_valid     <= 1'b0;
            s2_oob       <= 1'b0;
            s2_owner     <= OWN_DISP;
            disp_valid   <= 1'b0;
            disp_data    <= '0;
            q_ack        <= 1'b0;
            q_data       <= '0;
        end else begin
            s1_valid <= disp_req || qry_grant;
            if (disp_req) begin
                s1_owner <= OWN_DISP;
                s1_oob   <= disp_oob;
                if (!disp_oob) read_address <= disp_addr;
            end else if (qry_grant) begin
                s1_owner <= OWN_QRY;
                s1_oob   <= q_oob;
                if (!q_oob) read_address <= q_addr;
            end

            s2_valid <= s1_valid;
            s2_owner <= s1_owner;
            s2_oob   <= s1_oob;

            disp_valid <= s2_valid && (s2_owner == OWN_DISP);
            q_ack      <= s2_valid && (s2_owner == OWN_QRY);
            if (s2_valid && (s2_owner == OWN_DISP)) disp_data <= rd_value;
            if (s2_valid && (s2_owner == OWN_QRY))  q_data    <= rd_value;
        end
    end

    // Q_DONE holds until q_req drops so a held request cannot re-issue.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            q_state <= Q_IDLE;
        end else begin
            case (q_state)
                Q_IDLE:      if (q_req) q_state <= Q_WAIT_SLOT;
                Q_WAIT_SLOT: if (qry_grant) q_state <= Q_INFLIGHT;
                Q_INFLIGHT:  if (s2_valid && (s2_owner == OWN_QRY)) q_state <= Q_DONE;
                Q_DONE:      if (!q_req) q_state <= Q_IDLE;
                default:     q_state <= Q_IDLE;
            endcase
        end
    end

    // Out-of-range writes still ack but leave we low and the RAM-side address untouched.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            w_state       <= W_IDLE;
            we            <= 1'b0;
            w_ack         <= 1'b0;
            write_address <= '0;
            data_In       <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (w_req && write_allowed) begin
                        w_state <= W_ISSUE;
                        w_ack   <= 1'b1;
                        we      <= !w_oob;
                        if (!w_oob) begin
                            write_address <= w_addr;
                            data_In       <= w_data;
                        end
                    end
                end
                W_ISSUE: begin
                    w_state <= W_DONE;
                    we      <= 1'b0;
                    w_ack   <= 1'b0;
                end
                W_DONE: if (!w_req) w_state <= W_IDLE;
                default: begin
                    w_state <= W_IDLE;
                    we      <= 1'b0;
                    w_ack   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_map_ram_arbiter.sv
// Bench for map_ram_arbiter: RAM environment, cycle-level behavioural model and directed vectors.
module tb_map_ram_arbiter;
    import map_pkg::*;

    localparam int              RD_W = 5;
    localparam int              WR_W = 8;
    localparam logic [RD_W-1:0] OOB  = 5'h00;

    logic              Clk, Reset;
    logic              disp_req, disp_valid;
    logic [9:0]        disp_x, disp_y;
    logic [RD_W-1:0]   disp_data;
    logic              q_req, q_ack;
    logic [9:0]        q_x, q_y;
    logic [RD_W-1:0]   q_data;
    logic              w_req, w_ack;
    logic [9:0]        w_x, w_y;
    logic [WR_W-1:0]   w_data;
    logic              disp_blank;
    logic [ADDR_W-1:0] read_address, write_address;
    logic [WR_W-1:0]   data_In;
    logic              we;
    logic [RD_W-1:0]   data_Out;

    int n_checks;
    int n_pass;

    map_ram_arbiter #(
        .MAP_W(MAP_W), .MAP_H(MAP_H), .RD_W(RD_W), .WR_W(WR_W), .OOB_VALUE(OOB)
    ) dut (
        .Clk(Clk), .Reset(Reset),
        .disp_req(disp_req), .disp_x(disp_x), .disp_y(disp_y),
        .disp_valid(disp_valid), .disp_data(disp_data),
        .q_req(q_req), .q_x(q_x), .q_y(q_y), .q_ack(q_ack), .q_data(q_data),
        .w_req(w_req), .w_x(w_x), .w_y(w_y), .w_data(w_data), .w_ack(w_ack),
        .disp_blank(disp_blank),
        .read_address(read_address), .write_address(write_address),
        .data_In(data_In), .we(we), .data_Out(data_Out)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [7:0] pat(input int a);
        return 8'(a * 7 + 3);
    endfunction

    function automatic bit is_oob(input int x, input int y);
        return (x >= MAP_W) || (y >= MAP_H);
    endfunction

    function automatic int lin(input int x, input int y);
        return y * MAP_W + x;
    endfunction

    // RAM environment: registered read, read-before-write, unwritten cells hold pat(addr)
    bit         ram_wr[MAP_DEPTH];
    logic [7:0] ram_val[MAP_DEPTH];

    always @(posedge Clk) begin : ram_env
        int ra, wa;
        ra = int'(read_address);
        wa = int'(write_address);
        if (ra < MAP_DEPTH)
            data_Out <= ram_wr[ra] ? ram_val[ra][RD_W-1:0] : RD_W'(pat(ra));
        else
            data_Out <= '0;
        if (we && wa < MAP_DEPTH) begin
            ram_wr[wa]  <= 1'b1;
            ram_val[wa] <= data_In;
        end
    end

    // Behavioural model: reads issued at edge k resolve from memory at k+1 and appear at k+2
    bit              mm_wr[MAP_DEPTH];
    logic [7:0]      mm_val[MAP_DEPTH];
    int              cyc;
    bit              iss_valid[4], iss_qry[4], iss_oob[4];
    int              iss_addr[4];
    logic [RD_W-1:0] iss_data[4];
    bit              pend_we;
    int              pend_addr;
    logic [7:0]      pend_data;
    int              q_phase, w_phase;
    bit              e_disp_v, e_q_ack, e_we, e_w_ack;
    logic [RD_W-1:0] e_rd;
    int              e_ra, e_wa;
    logic [7:0]      e_wd;

    always @(posedge Clk or posedge Reset) begin : model
        int sn, sp, sp2;
        bit allowed, qry_issued;
        if (Reset) begin
            for (int i = 0; i < 4; i++) iss_valid[i] = 1'b0;
            pend_we = 1'b0;
            q_phase = 0;
            w_phase = 0;
            e_disp_v = 1'b0; e_q_ack = 1'b0; e_we = 1'b0; e_w_ack = 1'b0;
            e_rd = '0; e_ra = 0; e_wa = 0; e_wd = '0;
        end else begin
            sn  = cyc % 4;
            sp  = (cyc + 3) % 4;
            sp2 = (cyc + 2) % 4;
            if (iss_valid[sp] && !iss_oob[sp])
                iss_data[sp] = mm_wr[iss_addr[sp]] ? mm_val[iss_addr[sp]][RD_W-1:0]
                                                   : RD_W'(pat(iss_addr[sp]));
            e_disp_v = iss_valid[sp2] && !iss_qry[sp2];
            e_q_ack  = iss_valid[sp2] && iss_qry[sp2];
            e_rd     = iss_oob[sp2] ? OOB : iss_data[sp2];
            if (pend_we) begin
                mm_wr[pend_addr]  = 1'b1;
                mm_val[pend_addr] = pend_data;
                pend_we = 1'b0;
            end

            qry_issued    = 1'b0;
            iss_valid[sn] = 1'b0;
            if (disp_req) begin
                iss_valid[sn] = 1'b1;
                iss_qry[sn]   = 1'b0;
                iss_oob[sn]   = is_oob(int'(disp_x), int'(disp_y));
                iss_addr[sn]  = lin(int'(disp_x), int'(disp_y));
            end else if (q_phase == 1 && q_req) begin
                iss_valid[sn] = 1'b1;
                iss_qry[sn]   = 1'b1;
                iss_oob[sn]   = is_oob(int'(q_x), int'(q_y));
                iss_addr[sn]  = lin(int'(q_x), int'(q_y));
                qry_issued    = 1'b1;
            end
            if (iss_valid[sn] && !iss_oob[sn]) e_ra = iss_addr[sn];

            case (q_phase)
                0: if (q_req) q_phase = 1;
                1: if (qry_issued) q_phase = 2;
                2: if (e_q_ack) q_phase = 3;
                default: if (!q_req) q_phase = 0;
            endcase

`ifdef MAP_WRITE_IN_BLANK_EN
            allowed = disp_blank;
`else
            allowed = 1'b1;
`endif
            e_we    = 1'b0;
            e_w_ack = 1'b0;
            case (w_phase)
                0: if (w_req && allowed) begin
                    e_w_ack = 1'b1;
                    w_phase = 1;
                    if (!is_oob(int'(w_x), int'(w_y))) begin
                        e_we      = 1'b1;
                        e_wa      = lin(int'(w_x), int'(w_y));
                        e_wd      = w_data;
                        pend_we   = 1'b1;
                        pend_addr = e_wa;
                        pend_data = w_data;
                    end
                end
                1: w_phase = 2;
                default: if (!w_req) w_phase = 0;
            endcase
            cyc++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic checkOutput();
        check("read_address", 32'(read_address), 32'(e_ra));
        check("disp_valid", 32'(disp_valid), 32'(e_disp_v));
        if (e_disp_v) check("disp_data", 32'(disp_data), 32'(e_rd));
        check("q_ack", 32'(q_ack), 32'(e_q_ack));
        if (e_q_ack) check("q_data", 32'(q_data), 32'(e_rd));
        check("we", 32'(we), 32'(e_we));
        if (e_we) begin
            check("write_address", 32'(write_address), 32'(e_wa));
            check("data_In", 32'(data_In), 32'(e_wd));
        end
        check("w_ack", 32'(w_ack), 32'(e_w_ack));
    endtask

    always @(posedge Clk) begin
        #2;
        if (!Reset) checkOutput();
    end

    task automatic tick();
        @(negedge Clk);
    endtask

    task automatic applyStimulus(input bit dr, input int dx, input int dy,
                                 input bit qr, input int qx, input int qy);
        disp_req = dr; disp_x = 10'(dx); disp_y = 10'(dy);
        q_req    = qr; q_x    = 10'(qx); q_y    = 10'(qy);
    endtask

    task automatic setWrite(input bit wr, input int wx, input int wy,
                            input logic [7:0] wd, input bit blank);
        w_req = wr; w_x = 10'(wx); w_y = 10'(wy); w_data = wd; disp_blank = blank;
    endtask

    initial begin : stimulus
        bit              we_seen;
        int              ack_cnt, ack_at;
        logic [RD_W-1:0] ack_data;
        n_checks = 0;
        n_pass   = 0;
        Reset    = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0);
        setWrite(0, 0, 0, 8'h00, 0);
        repeat (3) tick();
        Reset = 1'b0;
        check("rst_read_address", 32'(read_address), 32'd0);
        check("rst_write_address", 32'(write_address), 32'd0);
        check("rst_disp_valid", 32'(disp_valid), 32'd0);
        check("rst_q_ack", 32'(q_ack), 32'd0);
        check("rst_we", 32'(we), 32'd0);
        tick();

        // display fetch (5,2) -> address 645, pattern value 0xA6 -> 5'h06
        applyStimulus(1, 5, 2, 0, 0, 0);
        tick();
        check("disp_addr_645", 32'(read_address), 32'd645);
        applyStimulus(0, 0, 0, 0, 0, 0);
        tick();
        check("disp_not_early", 32'(disp_valid), 32'd0);
        tick();
        check("disp_valid_n2", 32'(disp_valid), 32'd1);
        check("disp_data_645", 32'(disp_data), 32'h06);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, i * 37, i * 25, 0, 0, 0);
            tick();
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        repeat (3) tick();

        // held query behind 6 display cycles; (100,50) -> 16100, value 5'h1F
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 300 + i, 200 + i, 1, 100, 50);
            tick();
        end
        applyStimulus(0, 0, 0, 1, 100, 50);
        tick();
        check("qry_addr_16100", 32'(read_address), 32'd16100);
        tick();
        check("qry_ack_not_early", 32'(q_ack), 32'd0);
        tick();
        check("qry_ack_16100", 32'(q_ack), 32'd1);
        check("qry_data_16100", 32'(q_data), 32'h1F);
        applyStimulus(0, 0, 0, 0, 0, 0);
        repeat (2) tick();

        applyStimulus(1, 320, 0, 0, 0, 0);
        tick();
        check("oob_disp_addr_hold", 32'(read_address), 32'd16100);
        applyStimulus(0, 0, 0, 0, 0, 0);
        repeat (2) tick();
        check("oob_disp_valid", 32'(disp_valid), 32'd1);
        check("oob_disp_data", 32'(disp_data), 32'(OOB));

        applyStimulus(0, 0, 0, 1, 0, 240);
        repeat (4) tick();
        check("oob_qry_ack", 32'(q_ack), 32'd1);
        check("oob_qry_data", 32'(q_data), 32'(OOB));
        check("oob_qry_addr_hold", 32'(read_address), 32'd16100);
        applyStimulus(0, 0, 0, 0, 0, 0);
        repeat (2) tick();

        // corner write then read-back through a query
        setWrite(1, 319, 239, 8'h1F, 1);
        tick();
        check("wr_we", 32'(we), 32'd1);
        check("wr_addr_76799", 32'(write_address), 32'd76799);
        check("wr_data", 32'(data_In), 32'h1F);
        check("wr_ack", 32'(w_ack), 32'd1);
        tick();
        check("wr_we_single", 32'(we), 32'd0);
        check("wr_ack_single", 32'(w_ack), 32'd0);
        setWrite(0, 0, 0, 8'h00, 1);
        tick();
        applyStimulus(0, 0, 0, 1, 319, 239);
        repeat (4) tick();
        check("readback_ack", 32'(q_ack), 32'd1);
        check("readback_data", 32'(q_data), 32'h1F);
        applyStimulus(0, 0, 0, 0, 0, 0);
        repeat (2) tick();

`ifdef MAP_WRITE_IN_BLANK_EN
        setWrite(1, 11, 10, 8'hAA, 0);
        we_seen = 1'b0;
        repeat (20) begin
            tick();
            if (we) we_seen = 1'b1;
        end
        check("blank_hold_we", 32'(we_seen), 32'd0);
        disp_blank = 1'b1;
        tick();
        check("blank_release_we", 32'(we), 32'd1);
`else
        setWrite(1, 11, 10, 8'hAA, 0);
        we_seen = 1'b0;
        tick();
        if (we) we_seen = 1'b1;
        check("write_ignores_blank", 32'(we_seen), 32'd1);
`endif
        tick();
        setWrite(0, 0, 0, 8'h00, 0);
        repeat (2) tick();

        // reset while (10,10) is in flight; held request retries once, address 3210 -> 5'h09
        applyStimulus(0, 0, 0, 1, 10, 10);
        repeat (2) tick();
        Reset = 1'b1;
        tick();
        Reset    = 1'b0;
        ack_cnt  = 0;
        ack_at   = 0;
        ack_data = '0;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (q_ack) begin
                ack_cnt++;
                if (ack_at == 0) begin
                    ack_at   = t;
                    ack_data = q_data;
                end
            end
        end
        check("rst_retry_ack_count", 32'(ack_cnt), 32'd1);
        check("rst_retry_ack_cycle", 32'(ack_at), 32'd4);
        check("rst_retry_data", 32'(ack_data), 32'h09);
        applyStimulus(0, 0, 0, 0, 0, 0);
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: run exceeded its time limit");
        $fatal(1, "[TB] timeout");
    end

endmodule
